// File: rtl/program_fetch_sequencer.sv
// Purpose: owns the PC, drives the async-read program ROM address and registers each fetched word into a one-entry output slot.
// Latency: start -> first word valid after 2 edges; one word per cycle while decode keeps instr_ready high.
// Backpressure: slot holds (PC frozen) while instr_valid && !instr_ready; a redirect flushes the slot and costs one bubble.
//
// Ports:
//   clk, reset (async active-low)      - clock and reset
//   start                              - one-cycle pulse, (re)starts fetching at RESET_PC from IDLE/FAULT
//   redirect_valid / redirect_target   - branch/jump: load PC, flush slot (FETCH only)
//   rom_address / rom_instruction      - ROM byte address (= PC register) and same-cycle read data
//   instr_valid / instr_ready          - output slot handshake toward decode
//   instr_out / instr_pc               - slot contents: fetched word and its byte address
//   fault / fault_pc                   - sticky illegal-fetch flag and offending PC
//   instr_count                        - number of completed handshakes (wraps)
module program_fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_instruction,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc,
    output logic [DATA_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Word-index limit expressed in the width of PC[DATA_WIDTH-1:2].
    localparam logic [DATA_WIDTH-3:0] DEPTH_LIM = (DATA_WIDTH-2)'(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE   = DATA_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;

    logic xfer;
    logic slot_free;
    logic pc_illegal;

    assign xfer       = valid_q && instr_ready;
    assign slot_free  = !valid_q || instr_ready;
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q[DATA_WIDTH-1:2] >= DEPTH_LIM);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        // A handshake counts in every state, including the cycle a redirect flushes the slot.
        count_d    = xfer ? count_q + CNT_ONE : count_q;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    // Target legality is checked when it becomes the capture PC next cycle.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    if (pc_illegal) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        valid_d    = 1'b0;
                    end else begin
                        instr_d = rom_instruction;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
            end
            default: begin
                // IDLE and FAULT: only start does anything; redirects are dropped.
                valid_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    count_d = '0;
                    fault_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ipc_q      <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign rom_address = pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_program_fetch_sequencer.sv
module tb_program_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] rom_address;
    logic [31:0] rom_instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] instr_count;

    int checks = 0;
    int fails  = 0;

    program_fetch_sequencer #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .rom_address    (rom_address),
        .rom_instruction(rom_instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    // ROM: word i holds 0x1000_0000 + i, async read.
    assign rom_instruction = 32'h1000_0000 + (rom_address >> 2);

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; redirect_valid = 0; redirect_target = 0; instr_ready = 0;
        reset = 0;
        #3;
        step();
        reset = 1;
    endtask

    // Reset then start; returns 1ns after the edge that entered FETCH.
    task automatic begin_fetch();
        do_reset();
        instr_ready = 1;
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        #3;
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b want 0", fault); end
        checks++; if (instr_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", instr_count); end
        checks++; if (rom_address !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", rom_address); end
        checks++; if (instr_out !== 32'h0 || instr_pc !== 32'h0 || fault_pc !== 32'h0) begin
            fails++; $display("FAIL reset_regs got out=%h pc=%h fpc=%h want 0", instr_out, instr_pc, fault_pc); end
        step();
        reset = 1;
        // Redirect and missing start in IDLE must leave everything idle.
        redirect_valid = 1; redirect_target = 32'h40;
        step();
        redirect_valid = 0;
        checks++; if (rom_address !== 32'h0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL idle_redirect got addr=%h valid=%0b want 0/0", rom_address, instr_valid); end
    endtask

    task automatic test_stream();
        begin_fetch();
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_lat got valid=%0b want 0", instr_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0000 + i || instr_pc !== 32'(4 * i)) begin
                fails++;
                $display("FAIL stream_word%0d got v=%0b out=%h pc=%h want 1/%h/%h",
                         i, instr_valid, instr_out, instr_pc, 32'h1000_0000 + i, 4 * i);
            end
        end
        step();
        checks++; if (instr_count !== 32'd5) begin fails++; $display("FAIL stream_count got %0d want 5", instr_count); end
    endtask

    task automatic test_stall();
        begin_fetch();
        step(); step(); step();
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0002 || instr_pc !== 32'h8 ||
                rom_address !== 32'hC || instr_count !== 32'd2) begin
                fails++;
                $display("FAIL stall%0d got v=%0b out=%h pc=%h addr=%h cnt=%0d want 1/10000002/8/c/2",
                         i, instr_valid, instr_out, instr_pc, rom_address, instr_count);
            end
        end
        instr_ready = 1;
        step();
        checks++; if (instr_out !== 32'h1000_0003 || instr_pc !== 32'hC || instr_count !== 32'd3) begin
            fails++; $display("FAIL stall_release got out=%h pc=%h cnt=%0d want 10000003/c/3", instr_out, instr_pc, instr_count); end
        step();
        checks++; if (instr_out !== 32'h1000_0004 || instr_count !== 32'd4) begin
            fails++; $display("FAIL stall_next got out=%h cnt=%0d want 10000004/4", instr_out, instr_count); end
    endtask

    task automatic test_redirect();
        begin_fetch();
        step(); step();
        redirect_valid = 1; redirect_target = 32'h20;
        step();
        redirect_valid = 0;
        checks++; if (instr_valid !== 1'b0 || instr_count !== 32'd2 || rom_address !== 32'h20) begin
            fails++; $display("FAIL redirect_flush got v=%0b cnt=%0d addr=%h want 0/2/20", instr_valid, instr_count, rom_address); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0008 || instr_pc !== 32'h20) begin
            fails++; $display("FAIL redirect_target got v=%0b out=%h pc=%h want 1/10000008/20", instr_valid, instr_out, instr_pc); end
    endtask

    task automatic test_end_fault();
        begin_fetch();
        for (int i = 0; i < 32; i++) step();
        checks++; if (instr_out !== 32'h1000_001F || instr_pc !== 32'h7C || fault !== 1'b0) begin
            fails++; $display("FAIL last_word got out=%h pc=%h fault=%0b want 1000001f/7c/0", instr_out, instr_pc, fault); end
        step();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h80 || instr_valid !== 1'b0 || instr_count !== 32'd32) begin
            fails++; $display("FAIL range_fault got f=%0b fpc=%h v=%0b cnt=%0d want 1/80/0/32", fault, fault_pc, instr_valid, instr_count); end
        redirect_valid = 1; redirect_target = 32'h10;
        step(); step();
        redirect_valid = 0;
        checks++; if (fault !== 1'b1 || rom_address !== 32'h80 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL fault_sticky got f=%0b addr=%h v=%0b want 1/80/0", fault, rom_address, instr_valid); end
        start = 1;
        step();
        start = 0;
        checks++; if (fault !== 1'b0 || instr_count !== 32'd0 || rom_address !== 32'h0) begin
            fails++; $display("FAIL fault_restart got f=%0b cnt=%0d addr=%h want 0/0/0", fault, instr_count, rom_address); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0000 || instr_pc !== 32'h0) begin
            fails++; $display("FAIL resume_word got v=%0b out=%h pc=%h want 1/10000000/0", instr_valid, instr_out, instr_pc); end
    endtask

    task automatic test_misaligned();
        begin_fetch();
        step();
        redirect_valid = 1; redirect_target = 32'h6;
        step();
        redirect_valid = 0;
        checks++; if (fault !== 1'b0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL misalign_early got f=%0b v=%0b want 0/0", fault, instr_valid); end
        step();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h6 || instr_count !== 32'd1) begin
            fails++; $display("FAIL misalign_fault got f=%0b fpc=%h cnt=%0d want 1/6/1", fault, fault_pc, instr_count); end
        // start and redirect together in FAULT: start wins.
        start = 1; redirect_valid = 1; redirect_target = 32'h40;
        step();
        start = 0; redirect_valid = 0;
        checks++; if (rom_address !== 32'h0 || fault !== 1'b0) begin
            fails++; $display("FAIL fault_start_redirect got addr=%h f=%0b want 0/0", rom_address, fault); end
        // Same in IDLE.
        do_reset();
        start = 1; redirect_valid = 1; redirect_target = 32'h40;
        step();
        start = 0; redirect_valid = 0;
        instr_ready = 1;
        step();
        checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1 || rom_address !== 32'h4) begin
            fails++; $display("FAIL idle_start_redirect got pc=%h v=%0b addr=%h want 0/1/4", instr_pc, instr_valid, rom_address); end
    endtask

    task automatic test_async_reset();
        begin_fetch();
        step(); step(); step();
        #2;
        reset = 0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fault !== 1'b0 || instr_count !== 32'd0 || rom_address !== 32'h0) begin
            fails++; $display("FAIL async_reset got v=%0b f=%0b cnt=%0d addr=%h want 0/0/0/0", instr_valid, fault, instr_count, rom_address); end
        step();
        reset = 1;
        step(); step();
        checks++; if (instr_valid !== 1'b0 || rom_address !== 32'h0) begin
            fails++; $display("FAIL post_reset_idle got v=%0b addr=%h want 0/0", instr_valid, rom_address); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_end_fault();
        test_misaligned();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
